// File: rtl/nios_system_cpu_2_dct_pkg.sv
// Shared widths and accumulator state encoding for the CPU 2 debug
// compressed-trace frame packer.
package nios_system_cpu_2_dct_pkg;

    localparam int ATOM_W    = 2;
    localparam int NUM_SLOTS = 15;
    localparam int DCT_W     = ATOM_W * NUM_SLOTS;
    localparam int CNT_W     = 4;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } acc_state_e;

endpackage

// File: rtl/nios_system_cpu_2_dct_out_reg.sv
// One-entry valid/ready holding register. Payload is stable while the
// entry is valid and not being taken.
module nios_system_cpu_2_dct_out_reg #(
    parameter int W = 34
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready
);

    logic         valid_q;
    logic [W-1:0] data_q;
    logic         load;

    // Accepting while draining lets frames go back-to-back without a bubble.
    assign in_ready  = !valid_q || out_ready;
    assign load      = in_valid && in_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            if (load) begin
                data_q  <= in_data;
                valid_q <= 1'b1;
            end else if (out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/nios_system_cpu_2_dct_packer.sv
// Packs 2-bit trace atoms LSB-first into 30-bit frames with an occupancy
// count, and hands them to the trace consumer over valid/ready.
module nios_system_cpu_2_dct_packer
    import nios_system_cpu_2_dct_pkg::*;
#(
    parameter int ATOM_W    = nios_system_cpu_2_dct_pkg::ATOM_W,
    parameter int NUM_SLOTS = nios_system_cpu_2_dct_pkg::NUM_SLOTS,
    parameter int CNT_W     = nios_system_cpu_2_dct_pkg::CNT_W
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            atom_valid,
    input  logic [ATOM_W-1:0]               atom,
    output logic                            atom_ready,
    input  logic                            flush,
    output logic [ATOM_W*NUM_SLOTS-1:0]     dct_buffer,
    output logic [CNT_W-1:0]                dct_count,
    output logic                            dct_valid,
    input  logic                            dct_ready,
    output logic                            drained
);

    localparam int DCT_W = ATOM_W * NUM_SLOTS;

    acc_state_e         state_q, state_d;
    logic [DCT_W-1:0]   acc_q, acc_d, acc_post, atom_ext;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_post;
    logic               flush_pend_q, flush_pend_d;
    logic               accept, flush_act, close, xfer, out_in_ready;
    logic [DCT_W+CNT_W-1:0] out_data;

    always_comb begin
        atom_ready   = (state_q == ST_FILL);
        accept       = atom_valid && atom_ready;
        atom_ext     = {{(DCT_W-ATOM_W){1'b0}}, atom};
        acc_post     = acc_q;
        cnt_post     = cnt_q;
        if (accept) begin
            acc_post = acc_q | (atom_ext << (cnt_q * ATOM_W));
            cnt_post = cnt_q + CNT_W'(1);
        end

        // Close decision looks at the contents including this cycle's atom.
        flush_act = flush || flush_pend_q;
        close     = (cnt_post == CNT_W'(NUM_SLOTS)) ||
                    (flush_act && (cnt_post != '0));
        xfer      = close && out_in_ready;

        state_d      = state_q;
        acc_d        = acc_post;
        cnt_d        = cnt_post;
        flush_pend_d = 1'b0;
        if (xfer) begin
            state_d = ST_FILL;
            acc_d   = '0;
            cnt_d   = '0;
        end else if (close) begin
            // Output busy: park the finished frame and remember any flush.
            state_d      = ST_HOLD;
            flush_pend_d = flush_act;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_FILL;
            acc_q        <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    nios_system_cpu_2_dct_out_reg #(
        .W(DCT_W + CNT_W)
    ) u_out_reg (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (close),
        .in_data   ({cnt_post, acc_post}),
        .in_ready  (out_in_ready),
        .out_valid (dct_valid),
        .out_data  (out_data),
        .out_ready (dct_ready)
    );

    assign dct_buffer = out_data[DCT_W-1:0];
    assign dct_count  = out_data[DCT_W+CNT_W-1:DCT_W];
    assign drained    = (cnt_q == '0) && !dct_valid && !flush_pend_q;

endmodule

// File: tb/tb_nios_system_cpu_2_dct_packer.sv
// Directed bench for the DCT packer: table of per-cycle vectors plus
// hand-written backpressure and reset sequences.
module tb_nios_system_cpu_2_dct_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        atom_valid;
    logic [1:0]  atom;
    logic        atom_ready;
    logic        flush;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        dct_valid;
    logic        dct_ready;
    logic        drained;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    nios_system_cpu_2_dct_packer dut (
        .clk        (clk),
        .reset      (reset),
        .atom_valid (atom_valid),
        .atom       (atom),
        .atom_ready (atom_ready),
        .flush      (flush),
        .dct_buffer (dct_buffer),
        .dct_count  (dct_count),
        .dct_valid  (dct_valid),
        .dct_ready  (dct_ready),
        .drained    (drained)
    );

    typedef struct {
        logic        av;
        logic [1:0]  a;
        logic        fl;
        logic        rdy;
        logic        e_vld;
        logic [29:0] e_buf;
        logic [3:0]  e_cnt;
        logic        e_drn;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(logic av, logic [1:0] a, logic fl, logic rdy,
                                logic e_vld, logic [29:0] e_buf, logic [3:0] e_cnt,
                                logic e_drn);
        vec_t v;
        v.av = av; v.a = a; v.fl = fl; v.rdy = rdy;
        v.e_vld = e_vld; v.e_buf = e_buf; v.e_cnt = e_cnt; v.e_drn = e_drn;
        return v;
    endfunction

    // Expected frame for atoms (start..start+n-1) mod 4, LSB-first.
    function automatic logic [29:0] frame(int start, int n);
        logic [29:0] f = '0;
        logic [29:0] v;
        for (int k = 0; k < n; k++) begin
            v = 30'((start + k) % 4);
            f = f | (v << (2 * k));
        end
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic [1:0] a, input logic fl, input logic rdy);
        atom_valid = av; atom = a; flush = fl; dct_ready = rdy;
    endtask

    initial begin
        int nacc;
        reset = 1'b1;
        drive(0, 0, 0, 0);
        tick(); tick();
        chk("rst dct_valid",  dct_valid,  0);
        chk("rst dct_buffer", dct_buffer, 0);
        chk("rst dct_count",  dct_count,  0);
        chk("rst atom_ready", atom_ready, 1);
        chk("rst drained",    drained,    1);
        reset = 1'b0;
        tick();

        // Full frame 0,1,2,3,0,... then idle.
        for (int i = 0; i < 15; i++)
            tbl.push_back(mk(1, 2'(i % 4), 0, 1, i == 14, 30'h24E4E4E4, 4'd15, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1));
        // 3,3,3 + flush, held one cycle, then taken; then an empty flush.
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 3, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 30'h3F, 4'd3, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 30'h3F, 4'd3, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 1));
        // Flush coincident with 5th atom: 1,2,3,0,1 -> 0x139.
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 2, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1, 1, 30'h139, 4'd5, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1));

        foreach (tbl[i]) begin
            drive(tbl[i].av, tbl[i].a, tbl[i].fl, tbl[i].rdy);
            chk($sformatf("vec%0d atom_ready", i), atom_ready, 1);
            tick();
            chk($sformatf("vec%0d dct_valid", i), dct_valid, tbl[i].e_vld);
            chk($sformatf("vec%0d drained", i), drained, tbl[i].e_drn);
            if (tbl[i].e_vld) begin
                chk($sformatf("vec%0d dct_buffer", i), dct_buffer, tbl[i].e_buf);
                chk($sformatf("vec%0d dct_count", i), dct_count, tbl[i].e_cnt);
            end
        end
        drive(0, 0, 0, 1);

        // 30 atoms back-to-back, consumer always ready.
        for (int i = 0; i < 30; i++) begin
            drive(1, 2'(i % 4), 0, 1);
            chk($sformatf("b2b%0d atom_ready", i), atom_ready, 1);
            tick();
            chk($sformatf("b2b%0d dct_valid", i), dct_valid, (i == 14 || i == 29));
            if (i == 14) chk("b2b f1 buffer", dct_buffer, frame(0, 15));
            if (i == 29) chk("b2b f2 buffer", dct_buffer, frame(15, 15));
            if (i == 14 || i == 29) chk($sformatf("b2b%0d count", i), dct_count, 15);
        end
        drive(0, 0, 0, 1);
        tick();
        chk("b2b drained", drained, 1);

        // Backpressure: offer 40 atoms, only two frames fit.
        nacc = 0;
        for (int c = 0; c < 40; c++) begin
            drive(1, 2'(nacc % 4), 0, 0);
            if (atom_ready) nacc++;
            tick();
            if (c > 30) chk($sformatf("bp stable%0d", c), dct_buffer, frame(0, 15));
        end
        chk("bp accepted", nacc, 30);
        chk("bp atom_ready low", atom_ready, 0);
        chk("bp dct_valid", dct_valid, 1);
        chk("bp dct_count", dct_count, 15);
        drive(1, 2'(nacc % 4), 0, 1);
        chk("bp hold atom_ready", atom_ready, 0);
        tick();
        chk("bp f2 valid", dct_valid, 1);
        chk("bp f2 buffer", dct_buffer, frame(15, 15));
        chk("bp f2 count", dct_count, 15);
        chk("bp atom_ready back", atom_ready, 1);
        for (int c = 0; c < 10; c++) begin
            drive(1, 2'(nacc % 4), 0, 1);
            chk($sformatf("bp resume%0d atom_ready", c), atom_ready, 1);
            nacc++;
            tick();
        end
        drive(0, 0, 1, 1);
        tick();
        chk("bp tail valid", dct_valid, 1);
        chk("bp tail buffer", dct_buffer, frame(30, 10));
        chk("bp tail count", dct_count, 10);
        drive(0, 0, 0, 1);
        tick();
        chk("bp drained", drained, 1);

        // Reset with a waiting frame and 7 atoms accumulated.
        for (int i = 0; i < 22; i++) begin
            drive(1, 2'(i % 4), 0, 0);
            tick();
        end
        drive(0, 0, 0, 0);
        chk("pre-rst valid", dct_valid, 1);
        chk("pre-rst drained", drained, 0);
        #2 reset = 1'b1;
        #1;
        chk("mid-rst dct_valid",  dct_valid,  0);
        chk("mid-rst dct_buffer", dct_buffer, 0);
        chk("mid-rst dct_count",  dct_count,  0);
        chk("mid-rst atom_ready", atom_ready, 1);
        chk("mid-rst drained",    drained,    1);
        tick();
        reset = 1'b0;
        drive(1, 2, 1, 1);
        tick();
        chk("post-rst valid", dct_valid, 1);
        chk("post-rst count", dct_count, 1);
        chk("post-rst buffer", dct_buffer, 30'h2);
        drive(0, 0, 0, 1);
        tick();
        chk("post-rst drained", drained, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
